// File: rtl/lane_pkg.sv
// lane_pkg: symbol constants and lane FSM encoding shared by the serial lane blocks.
package lane_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COM = 8'hBC;
  typedef enum logic [1:0] {SEARCH = 2'd0, SYNC = 2'd1, ACTIVE = 2'd2} lane_state_t;
endpackage

// File: rtl/serial_to_parallel_lane_if.sv
// serial_to_parallel_lane_if: serial bit in, aligned byte/valid/strobe/active out.
interface serial_to_parallel_lane_if #(parameter int BYTE_W = lane_pkg::BYTE_W) ();
  logic              data_in;
  logic [BYTE_W-1:0] data_out;
  logic              valid_out;
  logic              byte_strobe;
  logic              active;
  modport master (output data_in, input data_out, valid_out, byte_strobe, active);
  modport slave (input data_in, output data_out, valid_out, byte_strobe, active);
endinterface

// File: rtl/s2p_shift_window.sv
// s2p_shift_window: serial shift register, bit counter and byte window/boundary generation.
module s2p_shift_window #(
  parameter int BYTE_W = lane_pkg::BYTE_W
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              data_in,
  input  logic              align,
  output logic [BYTE_W-1:0] win,
  output logic              boundary
);
  localparam int CW = $clog2(BYTE_W);
  logic [BYTE_W-2:0] shift;
  logic [CW-1:0]     bit_cnt;
  assign win = {shift, data_in};
  assign boundary = bit_cnt == CW'(BYTE_W - 1);
  // align marks the last bit of a byte, so the next bit is bit 0
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else begin
      shift   <= win[BYTE_W-2:0];
      bit_cnt <= (align || boundary) ? '0 : bit_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/serial_to_parallel_lane.sv
// serial_to_parallel_lane: COM-aligned serial-to-byte deserializer for one lane.
// Define S2P_LOSS_OF_LOCK_EN to drop lock after LOCK_COUNT misaligned COMs.
module serial_to_parallel_lane #(
  parameter int                BYTE_W     = lane_pkg::BYTE_W,
  parameter logic [BYTE_W-1:0] COM        = lane_pkg::COM,
  parameter int                LOCK_COUNT = 4
) (
  input logic                      clk_8f,
  input logic                      reset,
  serial_to_parallel_lane_if.slave lane
);
  import lane_pkg::*;
  localparam int NW = $clog2(LOCK_COUNT + 1);
  lane_state_t       state, state_nxt;
  logic [NW-1:0]     com_cnt, com_cnt_nxt;
  logic [BYTE_W-1:0] win, data_q;
  logic              boundary, is_com, align, lol, valid_q, strobe_q, emit;
  assign is_com = win == COM;
  assign align  = state == SEARCH && is_com;
  assign emit   = state == ACTIVE && boundary;
  s2p_shift_window #(.BYTE_W(BYTE_W)) u_win (
    .clk_8f  (clk_8f),
    .reset   (reset),
    .data_in (lane.data_in),
    .align   (align),
    .win     (win),
    .boundary(boundary)
  );
`ifdef S2P_LOSS_OF_LOCK_EN
  logic [NW-1:0] mis_cnt;
  assign lol = state == ACTIVE && !boundary && is_com && mis_cnt == NW'(LOCK_COUNT - 1);
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) mis_cnt <= '0;
    else if (state != ACTIVE || lol || (boundary && is_com)) mis_cnt <= '0;
    else if (is_com) mis_cnt <= mis_cnt + 1'b1;
  end
`else
  assign lol = 1'b0;
`endif
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state   <= SEARCH;
      com_cnt <= '0;
    end else begin
      state   <= state_nxt;
      com_cnt <= com_cnt_nxt;
    end
  end
  always_comb begin
    state_nxt   = state;
    com_cnt_nxt = com_cnt;
    case (state)
      SEARCH: if (is_com) begin
        com_cnt_nxt = NW'(1);
        state_nxt   = (LOCK_COUNT == 1) ? ACTIVE : SYNC;
      end
      SYNC: if (boundary) begin
        com_cnt_nxt = is_com ? com_cnt + 1'b1 : '0;
        state_nxt   = !is_com ? SEARCH : (com_cnt + 1'b1 == NW'(LOCK_COUNT)) ? ACTIVE : SYNC;
      end
      ACTIVE: if (lol) begin
        com_cnt_nxt = '0;
        state_nxt   = SEARCH;
      end
      default: state_nxt = SEARCH;
    endcase
  end
  always_comb lane.active = state == ACTIVE;
  // data_out keeps the last byte (COM included) until the next boundary
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= emit;
      if (emit) begin
        data_q  <= win;
        valid_q <= !is_com;
      end else if (lol) valid_q <= 1'b0;
    end
  end
  assign lane.data_out    = data_q;
  assign lane.valid_out   = valid_q;
  assign lane.byte_strobe = strobe_q;
endmodule
